// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// operands reduced to magnitudes at accept and the result sign restored when the op completes.
module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      Func3,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            DivByZero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        count_q, count_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              a_neg_q, a_neg_d;
  logic              b_zero_q, b_zero_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              dbz_q, dbz_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg_in, b_neg_in;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic              q_bit;
  logic [XLEN-1:0]   rem_new, quo_fix, rem_fix;
  logic [2*XLEN-1:0] step, prod_fix;

  // Datapath: acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    a_signed = (Func3 == 3'b001) || (Func3 == 3'b010) || (Func3 == 3'b100) || (Func3 == 3'b110);
    b_signed = (Func3 == 3'b001) || (Func3 == 3'b100) || (Func3 == 3'b110);
    a_neg_in = a_signed & A[XLEN-1];
    b_neg_in = b_signed & B[XLEN-1];
    a_mag_in = a_neg_in ? -A : A;
    b_mag_in = b_neg_in ? -B : B;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    q_bit    = rem_sh >= {1'b0, b_q};
    // When the trial subtraction succeeds the difference is below the divisor, so 64 bits suffice.
    rem_new  = q_bit ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
    step     = op_q[2] ? {rem_new, acc_q[XLEN-2:0], q_bit}
                       : {mul_sum, acc_q[XLEN-1:1]};

    prod_fix = neg_q ? -step : step;
    quo_fix  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_fix  = a_neg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    b_zero_d = b_zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d  = CALC;
          count_d  = 6'd0;
          op_d     = Func3;
          a_d      = A;
          b_d      = b_mag_in;
          acc_d    = {{XLEN{1'b0}}, a_mag_in};
          neg_d    = a_neg_in ^ b_neg_in;
          a_neg_d  = a_neg_in;
          b_zero_d = (B == '0);
          busy_d   = 1'b1;
        end
      end
      CALC: begin
        acc_d   = step;
        count_d = count_q + 6'd1;
        if (count_q == 6'd63) begin
          state_d = DONE;
          done_d  = 1'b1;
          dbz_d   = op_q[2] & b_zero_q;
          unique case (op_q)
            3'b000:                 result_d = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result_d = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         result_d = b_zero_q ? {XLEN{1'b1}} : quo_fix;
            default:                result_d = b_zero_q ? a_q : rem_fix;
          endcase
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      count_q  <= 6'd0;
      op_q     <= 3'b000;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      b_zero_q <= b_zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Result    = result_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against an arithmetic reference.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  Func3;
  logic [63:0] A, B;
  logic        Busy, Done, DivByZero;
  logic [63:0] Result;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  muldiv_unit #(.XLEN(64)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Func3(Func3), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Result(Result), .DivByZero(DivByZero)
  );

  always #5 Clk = ~Clk;

  // Reference: full-width arithmetic straight from the RV64M rules.
  function automatic void ref_model(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] res, output logic dbz);
    logic [127:0] ax_s, bx_s, ax_u, bx_u, p;
    ax_s = {{64{a[63]}}, a};
    bx_s = {{64{b[63]}}, b};
    ax_u = {64'd0, a};
    bx_u = {64'd0, b};
    p    = '0;
    res  = '0;
    case (f)
      3'b000: begin p = ax_u * bx_u; res = p[63:0]; end
      3'b001: begin p = ax_s * bx_s; res = p[127:64]; end
      3'b010: begin p = ax_s * bx_u; res = p[127:64]; end
      3'b011: begin p = ax_u * bx_u; res = p[127:64]; end
      3'b100: begin
        if (b == 64'd0) res = ONES;
        else if (a == MIN_NEG && b == ONES) res = a;
        else res = $signed(a) / $signed(b);
      end
      3'b101: res = (b == 64'd0) ? ONES : a / b;
      3'b110: begin
        if (b == 64'd0) res = a;
        else if (a == MIN_NEG && b == ONES) res = 64'd0;
        else res = $signed(a) % $signed(b);
      end
      default: res = (b == 64'd0) ? a : a % b;
    endcase
    dbz = f[2] && (b == 64'd0);
  endfunction

  // Issues one op from IDLE and observes 70 edges after the accept edge.
  task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] res, output logic dbz, output int lat,
                       output int busy_cycles, output int done_cnt);
    Func3 = f; A = a; B = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    Func3 = 3'($urandom_range(0, 7));
    lat = -1;
    res = Result;
    dbz = DivByZero;
    done_cnt = 0;
    busy_cycles = Busy ? 1 : 0;
    for (int e = 1; e <= 70; e++) begin
      @(posedge Clk); #1;
      if (Busy) busy_cycles++;
      if (Done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = e; res = Result; dbz = DivByZero;
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Func3 = 3'b000; A = 64'd3; B = 64'd4;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0; Start = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", Done); end
    checks++; if (Result !== 64'd0) begin errors++; $display("FAIL reset_result got=%h exp=0", Result); end
    checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", DivByZero); end
    @(posedge Clk); #1;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_no_start got=%b exp=0", Busy); end
    $display("reset: Busy=%b Done=%b Result=%h DivByZero=%b", Busy, Done, Result, DivByZero);
  endtask

  task automatic test_basic();
    logic [2:0]  f  [2] = '{3'b000, 3'b100};
    logic [63:0] av [2] = '{64'd3, 64'd40};
    logic [63:0] bv [2] = '{64'd4, 64'd5};
    logic [63:0] ev [2] = '{64'd12, 64'd8};
    logic [63:0] res; logic dbz; int lat, bc, dc;
    for (int i = 0; i < 2; i++) begin
      do_op(f[i], av[i], bv[i], res, dbz, lat, bc, dc);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL basic_result[%0d] got=%h exp=%h", i, res, ev[i]); end
      checks++; if (lat !== 64) begin errors++; $display("FAIL basic_latency[%0d] got=%0d exp=64 edges after accept", i, lat); end
      checks++; if (bc !== 65) begin errors++; $display("FAIL basic_busy_cycles[%0d] got=%0d exp=65", i, bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL basic_done_width[%0d] got=%0d exp=1", i, dc); end
      checks++; if (dbz !== 1'b0) begin errors++; $display("FAIL basic_dbz[%0d] got=%b exp=0", i, dbz); end
      $display("basic: f=%0d A=%h B=%h Result=%h latency=%0d busy=%0d", f[i], av[i], bv[i], res, lat, bc);
    end
  endtask

  task automatic test_signs();
    logic [2:0]  f  [4] = '{3'b011, 3'b001, 3'b110, 3'b100};
    logic [63:0] av [4] = '{ONES, ONES, -64'sd7, -64'sd7};
    logic [63:0] bv [4] = '{ONES, ONES, 64'd2, 64'd2};
    logic [63:0] ev [4] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'd0, ONES, -64'sd3};
    logic [63:0] res; logic dbz; int lat, bc, dc;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], av[i], bv[i], res, dbz, lat, bc, dc);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL sign_result[%0d] got=%h exp=%h", i, res, ev[i]); end
      checks++; if (lat !== 64) begin errors++; $display("FAIL sign_latency[%0d] got=%0d exp=64", i, lat); end
      $display("signs: f=%0d A=%h B=%h Result=%h", f[i], av[i], bv[i], res);
    end
  endtask

  task automatic test_special();
    logic [2:0]  f  [3] = '{3'b101, 3'b110, 3'b100};
    logic [63:0] av [3] = '{64'd123, -64'sd9, MIN_NEG};
    logic [63:0] bv [3] = '{64'd0, 64'd0, ONES};
    logic [63:0] ev [3] = '{ONES, -64'sd9, MIN_NEG};
    logic        ez [3] = '{1'b1, 1'b1, 1'b0};
    logic [63:0] res; logic dbz; int lat, bc, dc;
    for (int i = 0; i < 3; i++) begin
      do_op(f[i], av[i], bv[i], res, dbz, lat, bc, dc);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL special_result[%0d] got=%h exp=%h", i, res, ev[i]); end
      checks++; if (dbz !== ez[i]) begin errors++; $display("FAIL special_dbz[%0d] got=%b exp=%b", i, dbz, ez[i]); end
      checks++; if (lat !== 64) begin errors++; $display("FAIL special_latency[%0d] got=%0d exp=64", i, lat); end
      $display("special: f=%0d A=%h B=%h Result=%h DivByZero=%b", f[i], av[i], bv[i], res, dbz);
    end
  endtask

  task automatic test_start_ignored();
    int dc = 0, lat = -1;
    logic [63:0] res = '0;
    Func3 = 3'b100; A = 64'd40; B = 64'd5; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    for (int e = 1; e <= 140; e++) begin
      if (e == 10) begin Start = 1'b1; Func3 = 3'b000; A = 64'd6; B = 64'd7; end
      @(posedge Clk); #1;
      Start = 1'b0;
      if (Done) begin dc++; if (lat < 0) begin lat = e; res = Result; end end
    end
    checks++; if (res !== 64'd8) begin errors++; $display("FAIL ignore_result got=%h exp=8", res); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dc); end
    checks++; if (lat !== 64) begin errors++; $display("FAIL ignore_latency got=%0d exp=64", lat); end
    $display("start_ignored: Result=%h dones=%0d latency=%0d", res, dc, lat);
  endtask

  task automatic test_reset_abort();
    int dc = 0, lat, bc;
    logic [63:0] res; logic dbz;
    Func3 = 3'b100; A = 64'd100; B = 64'd7; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", Busy); end
    checks++; if (Result !== 64'd0) begin errors++; $display("FAIL abort_result got=%h exp=0", Result); end
    for (int e = 0; e < 70; e++) begin
      @(posedge Clk); #1;
      if (Done) dc++;
    end
    checks++; if (dc !== 0) begin errors++; $display("FAIL abort_done_count got=%0d exp=0", dc); end
    do_op(3'b000, 64'd6, 64'd7, res, dbz, lat, bc, dc);
    checks++; if (res !== 64'd42) begin errors++; $display("FAIL abort_next_mul got=%h exp=42", res); end
    checks++; if (lat !== 64) begin errors++; $display("FAIL abort_next_latency got=%0d exp=64", lat); end
    $display("reset_abort: next MUL Result=%h latency=%0d", res, lat);
  endtask

  task automatic test_back_to_back();
    int d0 = -1, d1 = -1, dc = 0;
    Func3 = 3'b000; A = 64'd3; B = 64'd4; Start = 1'b1;
    for (int e = 0; e <= 135; e++) begin
      @(posedge Clk); #1;
      if (Done && e > 0) begin
        dc++;
        if (d0 < 0) d0 = e; else if (d1 < 0) d1 = e;
        checks++; if (Result !== 64'd12) begin errors++; $display("FAIL b2b_result got=%h exp=12", Result); end
      end
    end
    Start = 1'b0;
    repeat (70) @(posedge Clk);
    #1;
    checks++; if (dc !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", dc); end
    checks++; if (d0 !== 64) begin errors++; $display("FAIL b2b_first_done got=%0d exp=64", d0); end
    checks++; if (d1 !== 130) begin errors++; $display("FAIL b2b_second_done got=%0d exp=130", d1); end
    $display("back_to_back: done edges %0d and %0d", d0, d1);
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return ONES;
      2: return MIN_NEG;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] f; logic [63:0] a, b, res, eres; logic dbz, edbz; int lat, bc, dc;
    for (int i = 0; i < 200; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      ref_model(f, a, b, eres, edbz);
      do_op(f, a, b, res, dbz, lat, bc, dc);
      checks++; if (res !== eres) begin errors++; $display("FAIL rand_result[%0d] f=%0d A=%h B=%h got=%h exp=%h", i, f, a, b, res, eres); end
      checks++; if (dbz !== edbz) begin errors++; $display("FAIL rand_dbz[%0d] f=%0d B=%h got=%b exp=%b", i, f, b, dbz, edbz); end
      checks++; if (lat !== 64) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=64", i, lat); end
      checks++; if (Result !== eres) begin errors++; $display("FAIL rand_hold[%0d] got=%h exp=%h", i, Result, eres); end
      $display("random %0d: f=%0d A=%h B=%h Result=%h DivByZero=%b latency=%0d", i, f, a, b, res, dbz, lat);
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Func3 = 3'b000; A = '0; B = '0;
    test_reset();
    test_basic();
    test_signs();
    test_special();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
